// File: rtl/memctl_pkg.sv
// Shared memory-controller definitions: command control-bit layout, the
// read/write direction state, and small helpers used by the command arbiter.
package memctl_pkg;

    localparam int CTL_W        = 6;
    localparam int CTL_CAS      = 5;
    localparam int CTL_RAS      = 4;
    localparam int CTL_WE       = 3;
    localparam int CTL_IS_CMD   = 2;
    localparam int CTL_IS_READ  = 1;
    localparam int CTL_IS_WRITE = 0;

    typedef enum logic [1:0] {
        DIR_RD       = 2'd0,
        DIR_WR       = 2'd1,
        DIR_RTW_WAIT = 2'd2,
        DIR_WTR_WAIT = 2'd3
    } dir_state_e;

    function automatic logic ctl_is_act(input logic [CTL_W-1:0] ctl);
        return ctl[CTL_RAS] & ~ctl[CTL_CAS] & ~ctl[CTL_WE] & ctl[CTL_IS_CMD];
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: picks the first request at or after ptr+1,
// returning a one-hot grant and its index. Purely combinational.
module rr_priority_encoder #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        // N is a power of two, so the modulo wrap is just truncation of ptr+k.
        for (int k = 1; k <= N; k++) begin
            cand = ptr_i + IW'(k);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Round-robin arbiter merging per-bank command streams into one registered
// command stream, enforcing read/write turnaround and ACT-to-ACT spacing.
module bank_cmd_arbiter
    import memctl_pkg::*;
#(
    parameter int NBANKS = 8,
    parameter int AW     = 17,
    parameter int BAW    = 3,
    localparam int BW    = $clog2(NBANKS)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NBANKS-1:0]         bm_cmd_valid,
    output logic [NBANKS-1:0]         bm_cmd_ready,
    input  logic [NBANKS*AW-1:0]      bm_cmd_a,
    input  logic [NBANKS*BAW-1:0]     bm_cmd_ba,
    input  logic [NBANKS*CTL_W-1:0]   bm_cmd_ctl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AW-1:0]             out_a,
    output logic [BAW-1:0]            out_ba,
    output logic [CTL_W-1:0]          out_ctl,
    output logic [BW-1:0]             out_bank,
    input  logic [7:0]                cfg_tWTR,
    input  logic [7:0]                cfg_tRTW,
    input  logic [7:0]                cfg_tRRD
);

    logic [NBANKS-1:0] is_rd, is_wr, is_act, eligible, grant_oh;
    logic [BW-1:0]     grant_idx, ptr_q;
    logic              any_elig, load, grant_fire, rrd_ok;
    logic              rd_elig_any, rd_valid_any, wr_elig_any, wr_valid_any;
    dir_state_e        dir_q, dir_d;
    logic [7:0]        turn_cnt_q, turn_cnt_d, rrd_cnt_q, rrd_cnt_d;

    logic              out_valid_q;
    logic [AW-1:0]     out_a_q;
    logic [BAW-1:0]    out_ba_q;
    logic [CTL_W-1:0]  out_ctl_q;
    logic [BW-1:0]     out_bank_q;

    assign rrd_ok = (rrd_cnt_q == 8'd0);

    for (genvar i = 0; i < NBANKS; i++) begin : g_class
        logic [CTL_W-1:0] ctl;
        assign ctl       = bm_cmd_ctl[i*CTL_W +: CTL_W];
        assign is_rd[i]  = ctl[CTL_IS_READ];
        assign is_wr[i]  = ctl[CTL_IS_WRITE] & ~ctl[CTL_IS_READ];
        assign is_act[i] = ctl_is_act(ctl) & ~ctl[CTL_IS_READ] & ~ctl[CTL_IS_WRITE];
        assign eligible[i] = bm_cmd_valid[i] & (is_rd[i]  ? (dir_q == DIR_RD) :
                                                is_wr[i]  ? (dir_q == DIR_WR) :
                                                is_act[i] ? rrd_ok : 1'b1);
    end

    assign rd_valid_any = |(bm_cmd_valid & is_rd);
    assign wr_valid_any = |(bm_cmd_valid & is_wr);
    assign rd_elig_any  = |(eligible & is_rd);
    assign wr_elig_any  = |(eligible & is_wr);

    rr_priority_encoder #(.N(NBANKS)) u_rr (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .grant_o (grant_oh),
        .idx_o   (grant_idx),
        .valid_o (any_elig)
    );

    // Reset gates the accept so no bankmachine sees a handshake for a dropped command.
    assign load         = ~out_valid_q | out_ready;
    assign grant_fire   = load & any_elig & ~sys_rst;
    assign bm_cmd_ready = grant_fire ? grant_oh : '0;

    always_comb begin
        dir_d      = dir_q;
        turn_cnt_d = turn_cnt_q;
        case (dir_q)
            DIR_RD: if (load && !rd_elig_any && wr_valid_any) begin
                dir_d      = DIR_RTW_WAIT;
                turn_cnt_d = cfg_tRTW;
            end
            DIR_WR: if (load && !wr_elig_any && rd_valid_any) begin
                dir_d      = DIR_WTR_WAIT;
                turn_cnt_d = cfg_tWTR;
            end
            DIR_RTW_WAIT: if (turn_cnt_q <= 8'd1) begin
                dir_d      = DIR_WR;
                turn_cnt_d = 8'd0;
            end else begin
                turn_cnt_d = turn_cnt_q - 8'd1;
            end
            DIR_WTR_WAIT: if (turn_cnt_q <= 8'd1) begin
                dir_d      = DIR_RD;
                turn_cnt_d = 8'd0;
            end else begin
                turn_cnt_d = turn_cnt_q - 8'd1;
            end
            default: dir_d = DIR_RD;
        endcase
    end

    // Counter holds the number of blocked cycles left, so ACTs land exactly cfg_tRRD apart.
    always_comb begin
        rrd_cnt_d = sat_dec(rrd_cnt_q);
        if (grant_fire && is_act[grant_idx]) begin
            rrd_cnt_d = sat_dec(cfg_tRRD);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dir_q       <= DIR_RD;
            turn_cnt_q  <= 8'd0;
            rrd_cnt_q   <= 8'd0;
            ptr_q       <= BW'(NBANKS - 1);
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_ba_q    <= '0;
            out_ctl_q   <= '0;
            out_bank_q  <= '0;
        end else begin
            dir_q      <= dir_d;
            turn_cnt_q <= turn_cnt_d;
            rrd_cnt_q  <= rrd_cnt_d;
            if (load) begin
                out_valid_q <= any_elig;
                if (any_elig) begin
                    out_a_q    <= bm_cmd_a[grant_idx*AW +: AW];
                    out_ba_q   <= bm_cmd_ba[grant_idx*BAW +: BAW];
                    out_ctl_q  <= bm_cmd_ctl[grant_idx*CTL_W +: CTL_W];
                    out_bank_q <= grant_idx;
                    ptr_q      <= grant_idx;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_ba    = out_ba_q;
    assign out_ctl   = out_ctl_q;
    assign out_bank  = out_bank_q;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Self-checking bench for bank_cmd_arbiter: vector tables of per-cycle
// valids/expected accepts, with a scoreboard matching registered outputs.
module tb_bank_cmd_arbiter;

    localparam int NB  = 8;
    localparam int AW  = 17;
    localparam int BAW = 3;

    // {cas,ras,we,is_cmd,is_read,is_write}
    localparam logic [5:0] C_RD  = 6'b100110;
    localparam logic [5:0] C_WR  = 6'b101101;
    localparam logic [5:0] C_ACT = 6'b010100;
    localparam logic [5:0] C_PRE = 6'b011100;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [NB-1:0]     bm_cmd_valid, bm_cmd_ready;
    logic [NB*AW-1:0]  bm_cmd_a;
    logic [NB*BAW-1:0] bm_cmd_ba;
    logic [NB*6-1:0]   bm_cmd_ctl;
    logic              out_valid, out_ready;
    logic [AW-1:0]     out_a;
    logic [BAW-1:0]    out_ba;
    logic [5:0]        out_ctl;
    logic [2:0]        out_bank;
    logic [7:0]        cfg_tWTR, cfg_tRTW, cfg_tRRD;
    logic [5:0]        ctl_tb [NB];

    typedef struct packed {
        logic [2:0]     bank;
        logic [AW-1:0]  a;
        logic [BAW-1:0] ba;
        logic [5:0]     ctl;
    } sb_item_t;

    typedef struct {
        logic [7:0] valid;
        logic [7:0] exp_ready;
        int         exp_ov;
    } vec_t;

    sb_item_t sb[$];
    vec_t     seq[$];
    vec_t     rr_tab[12];
    int       n_tests = 0;
    int       n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    function automatic logic [AW-1:0] a_of(input int i);
        return AW'(32'h0a5 + i * 32'h2d3);
    endfunction

    always_comb begin
        bm_cmd_a   = '0;
        bm_cmd_ba  = '0;
        bm_cmd_ctl = '0;
        for (int i = 0; i < NB; i++) begin
            bm_cmd_a[i*AW +: AW]    = a_of(i);
            bm_cmd_ba[i*BAW +: BAW] = BAW'(NB - 1 - i);
            bm_cmd_ctl[i*6 +: 6]    = ctl_tb[i];
        end
    end

    bank_cmd_arbiter #(.NBANKS(NB), .AW(AW), .BAW(BAW)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .bm_cmd_valid (bm_cmd_valid),
        .bm_cmd_ready (bm_cmd_ready),
        .bm_cmd_a     (bm_cmd_a),
        .bm_cmd_ba    (bm_cmd_ba),
        .bm_cmd_ctl   (bm_cmd_ctl),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_ba       (out_ba),
        .out_ctl      (out_ctl),
        .out_bank     (out_bank),
        .cfg_tWTR     (cfg_tWTR),
        .cfg_tRTW     (cfg_tRTW),
        .cfg_tRRD     (cfg_tRRD)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One cycle: check accepts at the negedge, retire any output into the
    // scoreboard, record the expected grant, then advance past the posedge.
    task automatic tick(input logic [NB-1:0] exp_rdy, input int exp_ov, input string name);
        sb_item_t got, exp;
        int       idx;
        idx = 0;
        @(negedge sys_clk);
        check({name, " ready"}, 64'(bm_cmd_ready), 64'(exp_rdy));
        if (exp_ov >= 0) check({name, " out_valid"}, 64'(out_valid), 64'(exp_ov));
        if (out_valid && out_ready) begin
            got = {out_bank, out_a, out_ba, out_ctl};
            if (sb.size() == 0) begin
                check({name, " unexpected out, sb size"}, 64'(sb.size()), 64'(1));
            end else begin
                exp = sb.pop_front();
                check({name, " out cmd"}, 64'(got), 64'(exp));
            end
        end
        if (exp_rdy != '0) begin
            for (int i = 0; i < NB; i++) if (exp_rdy[i]) idx = i;
            sb.push_back({3'(idx), a_of(idx), BAW'(NB - 1 - idx), ctl_tb[idx]});
        end
        @(posedge sys_clk);
        #1;
    endtask

    function automatic void add(input logic [7:0] v, input logic [7:0] r, input int ov);
        seq.push_back('{v, r, ov});
    endfunction

    task automatic run_seq(input string name);
        for (int k = 0; k < seq.size(); k++) begin
            bm_cmd_valid = seq[k].valid;
            tick(seq[k].exp_ready, seq[k].exp_ov, $sformatf("%s%0d", name, k));
        end
        bm_cmd_valid = '0;
        tick('0, -1, {name, " drain"});
        check({name, " sb empty"}, 64'(sb.size()), 64'(0));
        seq.delete();
    endtask

    task automatic do_reset(input string name);
        sys_rst      = 1'b1;
        bm_cmd_valid = '0;
        out_ready    = 1'b1;
        cfg_tWTR     = 8'd0;
        cfg_tRTW     = 8'd0;
        cfg_tRRD     = 8'd0;
        for (int i = 0; i < NB; i++) ctl_tb[i] = C_PRE;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check({name, " rst out_valid"}, 64'(out_valid), 64'(0));
        check({name, " rst out_a"},     64'(out_a),     64'(0));
        check({name, " rst out_ba"},    64'(out_ba),    64'(0));
        check({name, " rst out_ctl"},   64'(out_ctl),   64'(0));
        check({name, " rst out_bank"},  64'(out_bank),  64'(0));
        check({name, " rst ready"},     64'(bm_cmd_ready), 64'(0));
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin over PRE commands starting from reset (ptr = 7).
        rr_tab[0]  = '{8'h29, 8'h01, 0};
        rr_tab[1]  = '{8'h29, 8'h08, 1};
        rr_tab[2]  = '{8'h29, 8'h20, 1};
        rr_tab[3]  = '{8'h29, 8'h01, 1};
        rr_tab[4]  = '{8'h29, 8'h08, 1};
        rr_tab[5]  = '{8'h29, 8'h20, 1};
        rr_tab[6]  = '{8'h00, 8'h00, 1};
        rr_tab[7]  = '{8'hff, 8'h40, 0};
        rr_tab[8]  = '{8'h81, 8'h80, 1};
        rr_tab[9]  = '{8'h81, 8'h01, 1};
        rr_tab[10] = '{8'h40, 8'h40, 1};
        rr_tab[11] = '{8'h02, 8'h02, 1};

        sys_rst = 1'b1;
        for (int i = 0; i < NB; i++) ctl_tb[i] = C_PRE;

        // Single read on bank 2: accepted at cycle 0, output at cycle 1.
        do_reset("rd1");
        ctl_tb[2] = C_RD;
        add(8'h04, 8'h04, 0);
        run_seq("rd1_");

        do_reset("rr");
        for (int v = 0; v < 12; v++) seq.push_back(rr_tab[v]);
        run_seq("rr");

        // Read stream, then write on bank 1 behind a 4-cycle tRTW; PRE on 6 passes the wait.
        // Then WR->RD with tWTR=0 (one-cycle wait), writes winning the tie in WR.
        do_reset("ta");
        cfg_tRTW = 8'd4;
        cfg_tWTR = 8'd0;
        ctl_tb[0] = C_RD; ctl_tb[2] = C_RD; ctl_tb[3] = C_RD;
        ctl_tb[1] = C_WR; ctl_tb[4] = C_WR;
        add(8'h07, 8'h01, 0);
        add(8'h06, 8'h04, 1);
        add(8'h02, 8'h00, 1);
        add(8'h42, 8'h40, 0);
        add(8'h02, 8'h00, 1);
        add(8'h02, 8'h00, 0);
        add(8'h02, 8'h00, 0);
        add(8'h02, 8'h02, 0);
        add(8'h18, 8'h10, 1);
        add(8'h08, 8'h00, 1);
        add(8'h08, 8'h00, 0);
        add(8'h08, 8'h08, 0);
        run_seq("ta");

        // tRRD=3: second ACT exactly three cycles after the first; PRE passes meanwhile.
        do_reset("rrd");
        cfg_tRRD = 8'd3;
        ctl_tb[0] = C_ACT; ctl_tb[1] = C_ACT;
        add(8'h03, 8'h01, 0);
        add(8'h22, 8'h20, 1);
        add(8'h02, 8'h00, 1);
        add(8'h02, 8'h02, 0);
        run_seq("rrd");

        // tRRD=0: ACTs back to back.
        do_reset("rrd0");
        ctl_tb[0] = C_ACT; ctl_tb[1] = C_ACT;
        add(8'h03, 8'h01, 0);
        add(8'h02, 8'h02, 1);
        run_seq("rrd0_");

        // Downstream stall: output held, no accepts, then resume from ptr+1.
        do_reset("hold");
        bm_cmd_valid = 8'h0f;
        tick(8'h01, 0, "hold c0");
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(8'h00, 1, $sformatf("hold s%0d", c));
            check($sformatf("hold s%0d bank", c), 64'(out_bank), 64'(0));
            check($sformatf("hold s%0d a", c),    64'(out_a),    64'(a_of(0)));
        end
        out_ready = 1'b1;
        add(8'h0f, 8'h02, 1);
        add(8'h0f, 8'h04, 1);
        add(8'h0f, 8'h08, 1);
        run_seq("hold_r");

        // Asynchronous reset while a command is registered.
        do_reset("rm");
        bm_cmd_valid = 8'h24;
        tick(8'h04, 0, "rm c0");
        @(negedge sys_clk);
        check("rm out_valid before", 64'(out_valid), 64'(1));
        #1 sys_rst = 1'b1;
        #1;
        check("rm out_valid async", 64'(out_valid),    64'(0));
        check("rm out_bank async",  64'(out_bank),     64'(0));
        check("rm ready in reset",  64'(bm_cmd_ready), 64'(0));
        sb.delete();
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        add(8'h24, 8'h04, 0);
        run_seq("rm_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
